// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolutional-encoder frame sequencer:
//   - state_e  : frame sequencer states
//   - tag_t    : first/last framing tag that travels with each encoder issue
//   - conv_m() : number of encoder state bits for a given constraint length
//   - SYM_W    : width of one rate-1/2 encoder symbol
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int K_DEF = 6;
    localparam int SYM_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        DATA  = 3'd2,
        TAIL  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic first;
        logic last;
    } tag_t;

    function automatic int conv_m(input int k);
        return k - 1;
    endfunction

endpackage

// File: rtl/conv_frame_tagger.sv
// -----------------------------------------------------------------------------
// conv_frame_tagger
// Holds the first/last tag of the symbol currently inside the encoder,
// re-registers the encoder output with its framing markers, and flags
// protocol errors when the encoder output does not line up with the issues.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   issue_i, tag_i    encoder issue this cycle and its first/last tag
//   abort_i           drop the pending tag and suppress further symbols
//   clr_err_i         clear the sticky error (accepted frame start)
//   out_valid_i/sym_i encoder output
//   sym_valid_o, sym_data_o, sym_first_o, sym_last_o  registered symbol
//   err_o             sticky protocol error
// -----------------------------------------------------------------------------
module conv_frame_tagger
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_i,
    input  tag_t             tag_i,
    input  logic             abort_i,
    input  logic             clr_err_i,
    input  logic             out_valid_i,
    input  logic [SYM_W-1:0] out_sym_i,
    output logic             sym_valid_o,
    output logic [SYM_W-1:0] sym_data_o,
    output logic             sym_first_o,
    output logic             sym_last_o,
    output logic             err_o
);

    logic             tag_vld_q, tag_vld_d;
    tag_t             tag_q, tag_d;
    logic             sym_valid_q, sym_valid_d;
    logic [SYM_W-1:0] sym_data_q, sym_data_d;
    logic             sym_first_q, sym_first_d;
    logic             sym_last_q, sym_last_d;
    logic             err_q, err_d;

    always_comb begin
        tag_vld_d   = issue_i & ~abort_i;
        tag_d       = abort_i ? '0 : tag_i;
        // A symbol is only forwarded when it has a tag to pair with.
        sym_valid_d = out_valid_i & tag_vld_q & ~abort_i;
        sym_data_d  = sym_valid_d ? out_sym_i : sym_data_q;
        sym_first_d = sym_valid_d & tag_q.first;
        sym_last_d  = sym_valid_d & tag_q.last;
        err_d       = err_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end else if (!abort_i && (tag_vld_q != out_valid_i)) begin
            // Either an issued bit produced no symbol, or a symbol arrived untagged.
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q   <= 1'b0;
            tag_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            sym_first_q <= 1'b0;
            sym_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tag_vld_q   <= tag_vld_d;
            tag_q       <= tag_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            sym_first_q <= sym_first_d;
            sym_last_q  <= sym_last_d;
            err_q       <= err_d;
        end
    end

    assign sym_valid_o = sym_valid_q;
    assign sym_data_o  = sym_data_q;
    assign sym_first_o = sym_first_q;
    assign sym_last_o  = sym_last_q;
    assign err_o       = err_q;

endmodule

// File: rtl/conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv_frame_ctrl
// Frame sequencer for a rate-1/2 convolutional encoder. On an accepted start
// it loads the encoder state (seed or zero), streams frame_len payload bits
// from an upstream valid/ready source, optionally appends M zero tail bits,
// and re-registers encoder symbols with first/last markers.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, frame_len, zero_tail,
//   seed_en, seed_val             frame command (sampled on accepted start)
//   abort                         synchronous frame abort
//   busy, done, err               status (err is sticky until next start)
//   bit_valid, bit_in, bit_ready  upstream payload handshake
//   enc_seed_load, enc_seed_value,
//   enc_in_valid, enc_in_bit      encoder control/input
//   enc_out_valid, enc_out_sym    encoder output
//   sym_valid, sym_data,
//   sym_first, sym_last           framed symbol output
// -----------------------------------------------------------------------------
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter  int K     = K_DEF,
    parameter  int LEN_W = 16,
    localparam int M     = conv_m(K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             zero_tail,
    input  logic             seed_en,
    input  logic [M-1:0]     seed_val,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             enc_seed_load,
    output logic [M-1:0]     enc_seed_value,
    output logic             enc_in_valid,
    output logic             enc_in_bit,
    input  logic             enc_out_valid,
    input  logic [SYM_W-1:0] enc_out_sym,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym_data,
    output logic             sym_first,
    output logic             sym_last
);

    localparam int TW = $clog2(M + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    tail_cnt_q, tail_cnt_d;
    logic             zt_q, zt_d;
    logic [M-1:0]     seed_q, seed_d;
    logic             issued_q, issued_d;
    logic             accept;
    tag_t             tag;

    assign accept = (state_q == IDLE) && start && !abort;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        bit_cnt_d    = bit_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        zt_d         = zt_q;
        seed_d       = seed_q;
        issued_d     = issued_q;
        bit_ready    = 1'b0;
        enc_in_valid = 1'b0;
        enc_in_bit   = 1'b0;
        tag          = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SEED;
                    len_d      = frame_len;
                    zt_d       = zero_tail;
                    seed_d     = seed_en ? seed_val : '0;
                    bit_cnt_d  = '0;
                    tail_cnt_d = '0;
                    issued_d   = 1'b0;
                end
            end
            SEED: begin
                if (len_q != '0)  state_d = DATA;
                else if (zt_q)    state_d = TAIL;
                else              state_d = DONE;
            end
            DATA: begin
                // An aborting cycle never completes a handshake, so nothing
                // enters the encoder that the cleared tag pipeline would miss.
                bit_ready    = !abort;
                enc_in_valid = bit_valid && !abort;
                enc_in_bit   = bit_in;
                if (enc_in_valid) begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    if (bit_cnt_q == len_q - LEN_W'(1)) begin
                        state_d  = zt_q ? TAIL : DRAIN;
                        tag.last = !zt_q;
                    end
                end
            end
            TAIL: begin
                enc_in_valid = !abort;
                if (enc_in_valid) begin
                    tail_cnt_d = tail_cnt_q + TW'(1);
                    if (tail_cnt_q == TW'(M - 1)) begin
                        state_d  = DRAIN;
                        tag.last = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (sym_valid && sym_last) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tag.first = enc_in_valid && !issued_q;
        if (enc_in_valid) issued_d = 1'b1;

        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= '0;
            zt_q       <= 1'b0;
            seed_q     <= '0;
            issued_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            zt_q       <= zt_d;
            seed_q     <= seed_d;
            issued_q   <= issued_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign enc_seed_load  = (state_q == SEED);
    assign enc_seed_value = (state_q == SEED) ? seed_q : '0;
    assign done           = !abort && ((state_q == DONE) ||
                                       ((state_q == DRAIN) && sym_valid && sym_last));

    conv_frame_tagger u_tagger (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (enc_in_valid),
        .tag_i       (tag),
        .abort_i     (abort && (state_q != IDLE)),
        .clr_err_i   (accept),
        .out_valid_i (enc_out_valid),
        .out_sym_i   (enc_out_sym),
        .sym_valid_o (sym_valid),
        .sym_data_o  (sym_data),
        .sym_first_o (sym_first),
        .sym_last_o  (sym_last),
        .err_o       (err)
    );

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_frame_ctrl
// Bench for conv_frame_ctrl with a behavioural K=6 (G0=75, G1=53 octal)
// encoder attached. Expected symbols come from a sliding-window convolution
// over the frame's full input sequence, seeded from the initial state.
// -----------------------------------------------------------------------------
module tb_conv_frame_ctrl;
    import conv_pkg::*;

    localparam int K     = 6;
    localparam int M     = K - 1;
    localparam int LEN_W = 16;
    localparam logic [5:0] G0 = 6'o75;
    localparam logic [5:0] G1 = 6'o53;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start, zero_tail, seed_en, abort;
    logic [LEN_W-1:0] frame_len;
    logic [M-1:0]     seed_val;
    logic             busy, done, err;
    logic             bit_valid, bit_in, bit_ready;
    logic             enc_seed_load, enc_in_valid, enc_in_bit;
    logic [M-1:0]     enc_seed_value;
    logic             enc_out_valid;
    logic [1:0]       enc_out_sym;
    logic             sym_valid, sym_first, sym_last;
    logic [1:0]       sym_data;

    conv_frame_ctrl #(.K(K), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .zero_tail(zero_tail), .seed_en(seed_en), .seed_val(seed_val),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .enc_seed_load(enc_seed_load), .enc_seed_value(enc_seed_value),
        .enc_in_valid(enc_in_valid), .enc_in_bit(enc_in_bit),
        .enc_out_valid(enc_out_valid), .enc_out_sym(enc_out_sym),
        .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_first(sym_first), .sym_last(sym_last)
    );

    // Behavioural encoder; drop_idx suppresses out_valid for one issue.
    logic [M-1:0] e_st;
    int           e_cnt;
    int           drop_idx = -1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_st          <= '0;
            e_cnt         <= 0;
            enc_out_valid <= 1'b0;
            enc_out_sym   <= 2'b00;
        end else begin
            if (enc_seed_load) begin
                e_st  <= enc_seed_value;
                e_cnt <= 0;
            end else if (enc_in_valid) begin
                e_st  <= {enc_in_bit, e_st[M-1:1]};
                e_cnt <= e_cnt + 1;
            end
            enc_out_valid <= enc_in_valid && (e_cnt != drop_idx);
            enc_out_sym   <= {^({enc_in_bit, e_st} & G0), ^({enc_in_bit, e_st} & G1)};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] d;
        logic       f;
        logic       l;
        int         c;
    } sym_t;
    sym_t sq[$];
    int   dq[$];
    int   iq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (sym_valid) begin
                sym_t s;
                s.d = sym_data; s.f = sym_first; s.l = sym_last; s.c = cyc;
                sq.push_back(s);
            end
            if (done)         dq.push_back(cyc);
            if (enc_in_valid) iq.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    bit seq[$];
    bit pre_bits[$];

    // Symbol j of the frame: taps over the current input and the five before it,
    // reaching back into the seed (bit M-1 = most recent) for j < 5.
    function automatic logic [1:0] gold_sym(input logic [M-1:0] seed, input int j);
        logic a, b, w;
        logic [5:0] g0, g1;
        g0 = G0; g1 = G1; a = 1'b0; b = 1'b0;
        for (int d = 0; d <= M; d++) begin
            if (j - d >= 0) w = seq[j-d];
            else            w = seed[M - d + j];
            a ^= w & g0[M-d];
            b ^= w & g1[M-d];
        end
        return {a, b};
    endfunction

    task automatic run_frame(input int len, input bit zt, input bit sen, input logic [M-1:0] sv,
                             input int gap, input int abort_at, input int drop_at);
        int s0, d0, i0, idx, bud, n, a_cyc, seed_cyc, dcyc, late;
        logic [M-1:0] eff;
        logic [1:0]   exp_s[$];

        seq.delete();
        for (int i = 0; i < len; i++)
            seq.push_back((pre_bits.size() == len) ? pre_bits[i] : bit'($urandom_range(1)));
        pre_bits.delete();
        if (zt) for (int i = 0; i < M; i++) seq.push_back(1'b0);
        eff = sen ? sv : '0;
        for (int j = 0; j < seq.size(); j++)
            if (j != drop_at) exp_s.push_back(gold_sym(eff, j));
        drop_idx = drop_at;

        s0 = sq.size(); d0 = dq.size(); i0 = iq.size();
        @(posedge clk); #1;
        start = 1'b1; frame_len = LEN_W'(len); zero_tail = zt; seed_en = sen; seed_val = sv;
        @(posedge clk); #1;
        start = 1'b0; seed_val = M'($urandom); seed_en = 1'b0; zero_tail = 1'b0;
        seed_cyc = cyc;
        chk("busy_start", busy, 1);
        chk("err_clear", err, 0);
        chk("seed_load", enc_seed_load, 1);
        chk("seed_value", enc_seed_value, eff);
        @(posedge clk); #1;
        chk("seed_one_cycle", enc_seed_load, 0);

        idx = 0; bud = 0; a_cyc = -1;
        while (idx < len && bud < 40 * len + 40) begin
            bit_valid = ($urandom_range(99) >= gap);
            bit_in    = seq[idx];
            if (idx == abort_at && bit_valid && bit_ready) begin
                abort = 1'b1;
                a_cyc = cyc;
            end
            @(negedge clk);
            if (bit_valid && bit_ready) idx++;
            @(posedge clk); #1;
            abort = 1'b0;
            bud++;
            if (a_cyc >= 0) break;
        end
        bit_valid = 1'b0;

        if (a_cyc >= 0) begin
            chk("abort_idle", busy, 0);
            repeat (4) @(posedge clk);
            #1;
            late = 0;
            for (int k = s0; k < sq.size(); k++) if (sq[k].c > a_cyc) late++;
            chk("abort_no_sym", late, 0);
            chk("abort_no_done", dq.size() - d0, 0);
            chk("abort_err", err, 0);
            drop_idx = -1;
            return;
        end
        if (idx < len) chk("data_timeout", idx, len);

        bud = 0;
        while (!done && bud < 300) begin
            @(posedge clk); #1;
            bud++;
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
            drop_idx = -1;
            return;
        end
        dcyc = cyc;
        chk("busy_at_done", busy, 1);
        if (len == 0 && !zt) chk("empty_done_cyc", dcyc, seed_cyc + 1);
        @(posedge clk); #1;
        chk("busy_drop", busy, 0);

        n = sq.size() - s0;
        chk("sym_count", n, exp_s.size());
        for (int i = 0; i < n && i < exp_s.size(); i++) begin
            chk("sym_data", sq[s0+i].d, exp_s[i]);
            chk("sym_first", sq[s0+i].f, i == 0);
            chk("sym_last", sq[s0+i].l, i == exp_s.size() - 1);
        end
        chk("done_count", dq.size() - d0, 1);
        if (n > 0) chk("done_with_last", dq[d0], sq[s0+n-1].c);
        if (drop_at < 0) begin
            chk("issue_count", iq.size() - i0, n);
            for (int i = 0; i < n && i0 + i < iq.size(); i++)
                chk("latency", sq[s0+i].c - iq[i0+i], 2);
            if (zt && n >= M)
                for (int k = 1; k < M; k++)
                    chk("tail_contig", iq[i0+n-k] - iq[i0+n-k-1], 1);
        end
        chk("err_end", err, drop_at >= 0);
        drop_idx = -1;
    endtask

    int base;

    initial begin
        start = 0; frame_len = '0; zero_tail = 0; seed_en = 0; seed_val = '0;
        abort = 0; bit_valid = 0; bit_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_data", sym_data, 0);
        chk("rst_sym_marks", {sym_first, sym_last}, 0);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_seed", {enc_seed_load, enc_seed_value}, 0);
        chk("rst_enc_in", enc_in_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed 4-bit frame with tail, zero seed.
        pre_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        base = sq.size();
        run_frame(4, 1, 0, '0, 0, -1, -1);
        if (sq.size() > base) chk("first_sym_11", sq[base].d, 2'b11);
        else                  chk("first_sym_missing", sq.size(), base + 1);

        // Empty frame.
        base = sq.size();
        run_frame(0, 0, 0, '0, 0, -1, -1);

        // Seeded frame without tail.
        run_frame(3, 0, 1, 5'b10101, 0, -1, -1);

        // Long frame with 50% valid gaps.
        run_frame(100, 1, 1'($urandom), M'($urandom), 50, -1, -1);

        // Start and abort together in IDLE: command dropped.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; frame_len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_drop", busy, 0);

        // Abort on the 3rd handshake, then a full frame.
        run_frame(10, 1, 0, '0, 0, 2, -1);
        run_frame(8, 1, 1, M'($urandom), 30, -1, -1);

        // Missing encoder output -> sticky err, cleared by next start.
        run_frame(6, 1, 0, '0, 0, -1, 4);
        run_frame(5, 1, 0, '0, 20, -1, -1);

        // Asynchronous reset in the middle of a frame.
        @(posedge clk); #1;
        start = 1'b1; frame_len = 16'd20; zero_tail = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sym_valid", sym_valid, 0);
        chk("midrst_enc_in", enc_in_valid, 0);
        chk("midrst_ready", bit_ready, 0);
        bit_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(7, 0, 1, 5'b00111, 20, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
